// File: rtl/fifo_ctrl.sv
// Single-clock controller for a dual-port FIFO memory: pointers, enables,
// occupancy, status flags, registered read-valid and sticky error tracking.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clr_err,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [ADDR_WIDTH-1:0] raddr,
    output logic                  wen,
    output logic                  ren,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  rd_valid,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DepthCnt = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AfCnt    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] AeCnt    = AE_LEVEL[ADDR_WIDTH:0];

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Flags come from registered pointers only; requests never reach them.
    always_comb begin
        count        = wptr_q - rptr_q;
        full         = (count == DepthCnt);
        empty        = (count == '0);
        almost_full  = (count >= AfCnt);
        almost_empty = (count <= AeCnt);
        waddr        = wptr_q[ADDR_WIDTH-1:0];
        raddr        = rptr_q[ADDR_WIDTH-1:0];
        wen          = push & ~full;
        ren          = pop & ~empty;
        rd_valid     = rd_valid_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    // A new error in the same cycle as clr_err wins over the clear.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        rd_valid_d  = ren;
        overflow_d  = (overflow_q & ~clr_err) | (push & full);
        underflow_d = (underflow_q & ~clr_err) | (pop & empty);
        if (wen) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (ren) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Single-clock controller that sequences the team's dual-port FIFO memory: pointers, write/read enables, occupancy, status flags and error tracking.
- Sits between producer/consumer logic and the memory instance; both memory clock ports are tied to clk.
- Memory rdata is registered, so data is valid one cycle after an accepted pop; the controller flags this with rd_valid.

Parameters:
- ADDR_WIDTH, 3, memory address width; DEPTH = 2**ADDR_WIDTH (8).
- AF_LEVEL, 6, almost_full asserted when count >= AF_LEVEL; legal range 1..DEPTH.
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL; legal range 0..DEPTH-1.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- push  input  1  write request; memory data is supplied externally to wdata.
- pop  input  1  read request.
- clr_err  input  1  clears sticky overflow/underflow.
- waddr  output  ADDR_WIDTH  memory write address = wptr[ADDR_WIDTH-1:0].
- raddr  output  ADDR_WIDTH  memory read address = rptr[ADDR_WIDTH-1:0].
- wen  output  1  memory write enable.
- ren  output  1  memory read enable.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_LEVEL.
- almost_empty  output  1  count <= AE_LEVEL.
- count  output  ADDR_WIDTH+1  occupancy, 0..DEPTH.
- rd_valid  output  1  memory rdata valid this cycle.
- overflow  output  1  sticky: push rejected while full.
- underflow  output  1  sticky: pop rejected while empty.

Behaviour:
- Reset (async, rst_n=0): wptr=rptr=0, count=0, rd_valid=0, overflow=0, underflow=0. Outputs are then empty=1, full=0, almost_empty=1, almost_full=0, waddr=raddr=0, wen=ren=0.
- Pointers: wptr and rptr are ADDR_WIDTH+1 bits. The extra MSB disambiguates full from empty. Both wrap naturally modulo 2*DEPTH, so the address wraps DEPTH-1 -> 0.
- count = wptr - rptr, modulo 2**(ADDR_WIDTH+1). Count may be held as a register or derived from the pointers, but must match that value every cycle.
- Flag timing: full, empty, almost_* and count depend only on registered state. There is no combinational path from push or pop to any flag.
- wen = push & ~full. ren = pop & ~empty. These are combinational, same cycle as the request.
- Accepted push (wen=1): wptr increments at the clock edge.
- Accepted pop (ren=1): rptr increments at the clock edge. rd_valid=1 in the following cycle only.
- rd_valid is registered from ren. It is 0 in any cycle that does not follow an accepted pop.
- Push and pop together, 0 < count < DEPTH: both accepted, count unchanged, both pointers advance.
- Push and pop together, full: pop accepted, push rejected, overflow set; count goes DEPTH -> DEPTH-1.
- Push and pop together, empty: push accepted, pop rejected, underflow set; count goes 0 -> 1.
- Rejected requests never move pointers and never change memory.
- Sticky errors: overflow is set on (push & full); underflow is set on (pop & empty).
- clr_err clears both sticky errors at the next edge. If a new error occurs in the same cycle as clr_err, set wins.
- Reset mid-operation: all state returns to reset values immediately, and a pending rd_valid is dropped. Memory contents are not the controller's concern.

Test Plan:
- Reset then 8 consecutive pushes -> waddr 0..7, wen=1 each cycle.
  - After the 6th push: almost_full=1.
  - After the 8th push: full=1, count=8, empty=0.
- At full, push=1 -> wen=0, waddr stays 0, count stays 8, overflow=1 next cycle and held.
  - clr_err=1 -> overflow=0.
- 8 consecutive pops from full -> raddr 0..7, rd_valid=1 one cycle after each ren.
  - After the 7th pop: almost_empty=1.
  - After the 8th pop: empty=1, count=0.
  - Then pop=1 -> ren=0, underflow=1.
- Wrap: push 5, pop 5, then push 6 -> waddr sequence 5,6,7,0,1,2, count=6, no errors.
- At count=3, push=pop=1 for 4 cycles -> count stays 3, waddr and raddr each advance by 4, rd_valid=1 in cycles 2-5.
- Corner cases:
  - Simultaneous push+pop at empty -> count=1, underflow=1.
  - Simultaneous push+pop at full -> count=7, overflow=1.
  - clr_err in the same cycle as overflow -> overflow remains 1.
  - rst_n low mid-stream at count=5 with rd_valid pending -> count=0, empty=1, rd_valid=0 without a clock edge.
